// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for the 32x64 register file write port (we3/wa3/wd3).
// Optional read-port bypass is enabled with `define WBARB_FWD_EN.
module regfile_wb_arbiter #(
  parameter int N   = 64,
  parameter int AW  = 5,
  parameter int XZR = 31
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          v0,
  input  logic [AW-1:0] a0,
  input  logic [N-1:0]  d0,
  output logic          r0,
  input  logic          v1,
  input  logic [AW-1:0] a1,
  input  logic [N-1:0]  d1,
  output logic          r1,
  output logic          we3,
  output logic [AW-1:0] wa3,
  output logic [N-1:0]  wd3,
  output logic [1:0]    gnt,
  output logic          busy
`ifdef WBARB_FWD_EN
  ,
  input  logic [AW-1:0] fa1,
  input  logic [AW-1:0] fa2,
  output logic          fh1,
  output logic          fh2,
  output logic [N-1:0]  fd1,
  output logic [N-1:0]  fd2
`endif
);

  localparam logic [AW-1:0] XzrAddr = AW'(XZR);

  logic          full0_q, full0_d, full1_q, full1_d;
  logic          seq0_q, seq0_d, seq1_q, seq1_d;
  logic          rrPtr_q, rrPtr_d;
  logic [AW-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [N-1:0]  data0_q, data0_d, data1_q, data1_d;

  logic tieSel;
  logic acc0, acc1;
  logic keep0, keep1;

  // Grant looks only at held state, so ready never depends on valid.
  always_comb begin
    gnt    = 2'b00;
    tieSel = 1'b0;
    if (full0_q && full1_q) begin
      if (seq0_q != seq1_q) begin
        gnt = seq0_q ? 2'b01 : 2'b10;
      end else begin
        tieSel = 1'b1;
        gnt    = rrPtr_q ? 2'b10 : 2'b01;
      end
    end else if (full0_q) begin
      gnt = 2'b01;
    end else if (full1_q) begin
      gnt = 2'b10;
    end
  end

  assign r0   = !full0_q || gnt[0];
  assign r1   = !full1_q || gnt[1];
  assign acc0 = v0 && r0;
  assign acc1 = v1 && r1;
  assign busy = full0_q || full1_q;

  always_comb begin
    wa3 = '0;
    wd3 = '0;
    if (gnt[0]) begin
      wa3 = addr0_q;
      wd3 = data0_q;
    end else if (gnt[1]) begin
      wa3 = addr1_q;
      wd3 = data1_q;
    end
  end

  // XZR entries still use their grant cycle but never reach the register file.
  assign we3 = (|gnt) && (wa3 != XzrAddr);

  assign keep0 = full0_q && !gnt[0];
  assign keep1 = full1_q && !gnt[1];

  // A surviving entry becomes older when the other slot takes something new,
  // and loses its age mark once the other slot is emptied.
  always_comb begin
    full0_d = acc0 || keep0;
    full1_d = acc1 || keep1;
    addr0_d = acc0 ? a0 : addr0_q;
    data0_d = acc0 ? d0 : data0_q;
    addr1_d = acc1 ? a1 : addr1_q;
    data1_d = acc1 ? d1 : data1_q;
    seq0_d  = 1'b0;
    seq1_d  = 1'b0;
    if (keep0) seq0_d = acc1 ? 1'b1 : (gnt[1] ? 1'b0 : seq0_q);
    if (keep1) seq1_d = acc0 ? 1'b1 : (gnt[0] ? 1'b0 : seq1_q);
    rrPtr_d = rrPtr_q ^ tieSel;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full0_q <= 1'b0;
      full1_q <= 1'b0;
      seq0_q  <= 1'b0;
      seq1_q  <= 1'b0;
      rrPtr_q <= 1'b0;
      addr0_q <= '0;
      addr1_q <= '0;
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      full0_q <= full0_d;
      full1_q <= full1_d;
      seq0_q  <= seq0_d;
      seq1_q  <= seq1_d;
      rrPtr_q <= rrPtr_d;
      addr0_q <= addr0_d;
      addr1_q <= addr1_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
    end
  end

`ifdef WBARB_FWD_EN
  // On a double hit the entry that would be written last is the live value.
  logic ch1Newer;
  assign ch1Newer = (seq0_q != seq1_q) ? seq0_q : !rrPtr_q;

  function automatic logic [N:0] fwdLookup(input logic [AW-1:0] fa);
    logic m0, m1;
    m0 = full0_q && (addr0_q == fa) && (fa != XzrAddr);
    m1 = full1_q && (addr1_q == fa) && (fa != XzrAddr);
    if (m1 && (!m0 || ch1Newer)) return {1'b1, data1_q};
    if (m0)                      return {1'b1, data0_q};
    return '0;
  endfunction

  assign {fh1, fd1} = fwdLookup(fa1);
  assign {fh2, fd2} = fwdLookup(fa2);
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter with a register file model
// on the write port; ends with an asynchronous-reset sequence.
module tb_regfile_wb_arbiter;

  localparam int N  = 64;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          v0 = 1'b0, v1 = 1'b0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [N-1:0]  d0 = '0, d1 = '0;
  logic          r0, r1, we3, busy;
  logic [AW-1:0] wa3;
  logic [N-1:0]  wd3;
  logic [1:0]    gnt;
`ifdef WBARB_FWD_EN
  logic [AW-1:0] fa1 = '0, fa2 = '0;
  logic          fh1, fh2;
  logic [N-1:0]  fd1, fd2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .v0(v0), .a0(a0), .d0(d0), .r0(r0),
    .v1(v1), .a1(a1), .d1(d1), .r1(r1),
    .we3(we3), .wa3(wa3), .wd3(wd3), .gnt(gnt), .busy(busy)
`ifdef WBARB_FWD_EN
    , .fa1(fa1), .fa2(fa2), .fh1(fh1), .fh2(fh2), .fd1(fd1), .fd2(fd2)
`endif
  );

  // Register file model fed only by the write port.
  logic [N-1:0] rf [32];
  int xzrWrites = 0;
  always @(posedge clk) begin
    if (we3) begin
      rf[wa3] <= wd3;
      if (wa3 == 5'd31) xzrWrites <= xzrWrites + 1;
    end
  end

  typedef struct {
    logic          v0;
    logic [AW-1:0] a0;
    logic [N-1:0]  d0;
    logic          v1;
    logic [AW-1:0] a1;
    logic [N-1:0]  d1;
    logic          r0, r1;
    logic [1:0]    gnt;
    logic          we3;
    logic [AW-1:0] wa3;
    logic [N-1:0]  wd3;
    logic          busy;
  } vec_t;

  localparam int NumVecs = 22;
  vec_t vecs [NumVecs];

  function automatic vec_t mk(input logic iv0, input logic [4:0] ia0, input logic [63:0] id0,
                              input logic iv1, input logic [4:0] ia1, input logic [63:0] id1,
                              input logic er0, input logic er1, input logic [1:0] eg,
                              input logic ewe, input logic [4:0] ewa, input logic [63:0] ewd,
                              input logic eb);
    vec_t v;
    v.v0 = iv0; v.a0 = ia0; v.d0 = id0;
    v.v1 = iv1; v.a1 = ia1; v.d1 = id1;
    v.r0 = er0; v.r1 = er1; v.gnt = eg;
    v.we3 = ewe; v.wa3 = ewa; v.wd3 = ewd; v.busy = eb;
    return v;
  endfunction

  function automatic logic [79:0] expOf(input vec_t v);
    return {5'b0, v.r0, v.r1, v.gnt, v.we3, v.wa3, v.wd3, v.busy};
  endfunction

  function automatic logic [79:0] actOut();
    return {5'b0, r0, r1, gnt, we3, wa3, wd3, busy};
  endfunction

  task automatic applyStimulus(input vec_t v);
    v0 = v.v0; a0 = v.a0; d0 = v.d0;
    v1 = v.v1; a1 = v.a1; d1 = v.d1;
  endtask

  task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  localparam logic [79:0] ResetOut = {5'b0, 1'b1, 1'b1, 2'b00, 1'b0, 5'd0, 64'h0, 1'b0};

  initial begin
    // Fields: v0 a0 d0 | v1 a1 d1 || r0 r1 gnt we3 wa3 wd3 busy
    vecs[0]  = mk(1'b1, 5'd1,  64'h10,   1'b0, 5'd0,  64'h0,    1'b1, 1'b1, 2'b00, 1'b0, 5'd0,  64'h0,    1'b0);
    vecs[1]  = mk(1'b1, 5'd2,  64'h11,   1'b0, 5'd0,  64'h0,    1'b1, 1'b1, 2'b01, 1'b1, 5'd1,  64'h10,   1'b1);
    vecs[2]  = mk(1'b1, 5'd3,  64'h12,   1'b0, 5'd0,  64'h0,    1'b1, 1'b1, 2'b01, 1'b1, 5'd2,  64'h11,   1'b1);
    vecs[3]  = mk(1'b1, 5'd4,  64'h13,   1'b0, 5'd0,  64'h0,    1'b1, 1'b1, 2'b01, 1'b1, 5'd3,  64'h12,   1'b1);
    vecs[4]  = mk(1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b1, 1'b1, 2'b01, 1'b1, 5'd4,  64'h13,   1'b1);
    vecs[5]  = mk(1'b1, 5'd5,  64'h55,   1'b1, 5'd6,  64'h66,   1'b1, 1'b1, 2'b00, 1'b0, 5'd0,  64'h0,    1'b0);
    vecs[6]  = mk(1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b1, 1'b0, 2'b01, 1'b1, 5'd5,  64'h55,   1'b1);
    vecs[7]  = mk(1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b1, 1'b1, 2'b10, 1'b1, 5'd6,  64'h66,   1'b1);
    vecs[8]  = mk(1'b1, 5'd5,  64'h57,   1'b1, 5'd6,  64'h67,   1'b1, 1'b1, 2'b00, 1'b0, 5'd0,  64'h0,    1'b0);
    vecs[9]  = mk(1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b0, 1'b1, 2'b10, 1'b1, 5'd6,  64'h67,   1'b1);
    vecs[10] = mk(1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b1, 1'b1, 2'b01, 1'b1, 5'd5,  64'h57,   1'b1);
    vecs[11] = mk(1'b0, 5'd0,  64'h0,    1'b1, 5'd31, 64'hDEAD, 1'b1, 1'b1, 2'b00, 1'b0, 5'd0,  64'h0,    1'b0);
    vecs[12] = mk(1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b1, 1'b1, 2'b10, 1'b0, 5'd31, 64'hDEAD, 1'b1);
    vecs[13] = mk(1'b1, 5'd12, 64'hC0,   1'b1, 5'd7,  64'h71,   1'b1, 1'b1, 2'b00, 1'b0, 5'd0,  64'h0,    1'b0);
    vecs[14] = mk(1'b1, 5'd7,  64'h70,   1'b0, 5'd0,  64'h0,    1'b1, 1'b0, 2'b01, 1'b1, 5'd12, 64'hC0,   1'b1);
    vecs[15] = mk(1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b0, 1'b1, 2'b10, 1'b1, 5'd7,  64'h71,   1'b1);
    vecs[16] = mk(1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b1, 1'b1, 2'b01, 1'b1, 5'd7,  64'h70,   1'b1);
    vecs[17] = mk(1'b1, 5'd8,  64'h80,   1'b1, 5'd9,  64'h90,   1'b1, 1'b1, 2'b00, 1'b0, 5'd0,  64'h0,    1'b0);
    vecs[18] = mk(1'b1, 5'd10, 64'hA0,   1'b0, 5'd0,  64'h0,    1'b0, 1'b1, 2'b10, 1'b1, 5'd9,  64'h90,   1'b1);
    vecs[19] = mk(1'b1, 5'd10, 64'hA0,   1'b0, 5'd0,  64'h0,    1'b1, 1'b1, 2'b01, 1'b1, 5'd8,  64'h80,   1'b1);
    vecs[20] = mk(1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b1, 1'b1, 2'b01, 1'b1, 5'd10, 64'hA0,   1'b1);
    vecs[21] = mk(1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b1, 1'b1, 2'b00, 1'b0, 5'd0,  64'h0,    1'b0);

    #3;
    checkOutput("resetState", actOut(), ResetOut);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NumVecs; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d", i), actOut(), expOf(vecs[i]));
    end

    @(negedge clk);
    checkOutput("rfX1", {16'h0, rf[1]}, 80'h10);
    checkOutput("rfX4", {16'h0, rf[4]}, 80'h13);
    checkOutput("rfX5", {16'h0, rf[5]}, 80'h57);
    checkOutput("rfX6", {16'h0, rf[6]}, 80'h67);
    checkOutput("rfX7AgeOrder", {16'h0, rf[7]}, 80'h70);
    checkOutput("rfX8", {16'h0, rf[8]}, 80'h80);
    checkOutput("rfX9", {16'h0, rf[9]}, 80'h90);
    checkOutput("rfX10", {16'h0, rf[10]}, 80'hA0);
    checkOutput("rfX12", {16'h0, rf[12]}, 80'hC0);
    checkOutput("xzrWrites", 80'(xzrWrites), 80'd0);

    v0 = 1'b1; a0 = 5'd3; d0 = 64'hAA;
    @(posedge clk);
    #1;
    v0 = 1'b0;
    checkOutput("preResetGrant", {72'h0, gnt, we3, wa3}, {72'h0, 2'b01, 1'b1, 5'd3});
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("asyncReset", actOut(), ResetOut);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("noX3AfterReset", {16'h0, rf[3]}, 80'h12);
    checkOutput("idleAfterReset", actOut(), ResetOut);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
